regfile_write_arbiter: RTL and testbench

Sequencer/arbiter for the single write port of the 32×32 MIPS register file (`mips_regfile`).
- Shares the write port between two writeback requesters using valid/ready handshakes and round-robin priority.
- Provides a clear sequence that zeroes registers 1..31 one per cycle.
- Drives `wr_regnum`, `wr_data` and `writeenable` of the register file from registered outputs.

---
 rtl/regfile_write_arbiter_if.sv | 37 +++
 rtl/regfile_write_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between writeback requesters, the clear control
// and the register file write port.
interface regfile_write_arbiter_if #(
    parameter int width = 32
);
    logic             req0_valid;
    logic [4:0]       req0_regnum;
    logic [width-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [4:0]       req1_regnum;
    logic [width-1:0] req1_data;
    logic             req1_ready;
    logic             clear_start;
    logic             busy;
    logic [4:0]       wr_regnum;
    logic [width-1:0] wr_data;
    logic             writeenable;

    modport master (
        output req0_valid, req0_regnum, req0_data,
        input  req0_ready,
        output req1_valid, req1_regnum, req1_data,
        input  req1_ready,
        output clear_start,
        input  busy, wr_regnum, wr_data, writeenable
    );

    modport slave (
        input  req0_valid, req0_regnum, req0_data,
        output req0_ready,
        input  req1_valid, req1_regnum, req1_data,
        output req1_ready,
        input  clear_start,
        output busy, wr_regnum, wr_data, writeenable
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register file write port between two
// requesters, plus a one-register-per-cycle clear of registers 1..31.
module regfile_write_arbiter #(
    parameter int width = 32
) (
    input logic                    clock,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);
    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [4:0]       wr_regnum_q, wr_regnum_d;
    logic [width-1:0] wr_data_q, wr_data_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;
    logic             rdy0, rdy1;
    logic             take0, take1;

    // Grants: a side is blocked only by the other side's valid holding priority
    always_comb begin
        rdy0  = (state_q == ARB) && !bus.clear_start
                && !(bus.req1_valid && prio_q);
        rdy1  = (state_q == ARB) && !bus.clear_start
                && !(bus.req0_valid && !prio_q);
        take0 = bus.req0_valid && rdy0;
        take1 = bus.req1_valid && rdy1;
    end

    // Next state and registered write-port outputs
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        wr_regnum_d = wr_regnum_q;
        wr_data_d   = wr_data_q;
        we_d        = 1'b0;
        unique case (state_q)
            ARB: begin
                unique case (1'b1)
                    bus.clear_start: begin
                        state_d     = CLEAR;
                        cnt_d       = 5'd1;
                        wr_regnum_d = 5'd1;
                        wr_data_d   = '0;
                        we_d        = 1'b1;
                    end
                    take0: begin
                        wr_regnum_d = bus.req0_regnum;
                        wr_data_d   = bus.req0_data;
                        we_d        = (bus.req0_regnum != 5'd0);
                        prio_d      = 1'b1;
                    end
                    take1: begin
                        wr_regnum_d = bus.req1_regnum;
                        wr_data_d   = bus.req1_data;
                        we_d        = (bus.req1_regnum != 5'd0);
                        prio_d      = 1'b0;
                    end
                    default: we_d = 1'b0;
                endcase
            end
            CLEAR: begin
                // Terminal test comes first so cnt never wraps
                if (cnt_q == 5'd31) begin
                    state_d = ARB;
                end else begin
                    cnt_d       = cnt_q + 5'd1;
                    wr_regnum_d = cnt_q + 5'd1;
                    wr_data_d   = '0;
                    we_d        = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
        busy_d = (state_d == CLEAR);
    end

    // State and output registers; reset aborts any clear in progress
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ARB;
            prio_q      <= 1'b0;
            cnt_q       <= 5'd0;
            wr_regnum_q <= 5'd0;
            wr_data_q   <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            wr_regnum_q <= wr_regnum_d;
            wr_data_q   <= wr_data_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req0_ready  = rdy0;
    assign bus.req1_ready  = rdy1;
    assign bus.busy        = busy_q;
    assign bus.wr_regnum   = wr_regnum_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.writeenable = we_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios then random
// traffic against a cycle-indexed reference model and a shadow regfile.
module tb_regfile_write_arbiter;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail = 0;

    regfile_write_arbiter_if #(.width(W)) bus ();

    regfile_write_arbiter #(.width(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Register file fed by the DUT's write port
    logic [W-1:0] rf [32] = '{default: '0};
    always @(posedge clock)
        if (bus.writeenable && bus.wr_regnum != 5'd0)
            rf[bus.wr_regnum] <= bus.wr_data;

    // Reference model: clear position is derived from the cycle count
    logic [W-1:0] exp_rf [32];
    int           cyc;
    int           clr_n;
    logic [4:0]   m_reg;
    logic [W-1:0] m_data;
    bit           m_we;
    bit           m_prio;
    bit           t0, t1;
    bit           last_rdy0;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_clear();
        return clr_n >= 0 && (cyc - clr_n) <= 30;
    endfunction

    task automatic model_reset();
        m_reg  = 5'd0;
        m_data = '0;
        m_we   = 1'b0;
        m_prio = 1'b0;
        clr_n  = -1;
    endtask

    // One clock: check readys, predict the edge, check registered outputs
    task automatic step();
        bit r0, r1, cs;
        int d;
        #1;
        cs = bus.clear_start;
        r0 = !in_clear() && !cs && !(bus.req1_valid && m_prio);
        r1 = !in_clear() && !cs && !(bus.req0_valid && !m_prio);
        chk("req0_ready", bus.req0_ready, r0);
        chk("req1_ready", bus.req1_ready, r1);
        last_rdy0 = bus.req0_ready;
        t0 = bus.req0_valid && r0;
        t1 = bus.req1_valid && r1;
        if (m_we && m_reg != 5'd0) exp_rf[m_reg] = m_data;
        if (in_clear()) begin
            d = cyc + 1 - clr_n;
            if (d == 31) m_we = 1'b0;
            else begin
                m_reg  = 5'(d + 1);
                m_data = '0;
                m_we   = 1'b1;
            end
        end else if (cs) begin
            clr_n  = cyc + 1;
            m_reg  = 5'd1;
            m_data = '0;
            m_we   = 1'b1;
        end else if (t0) begin
            m_reg  = bus.req0_regnum;
            m_data = bus.req0_data;
            m_we   = (bus.req0_regnum != 5'd0);
            m_prio = 1'b1;
        end else if (t1) begin
            m_reg  = bus.req1_regnum;
            m_data = bus.req1_data;
            m_we   = (bus.req1_regnum != 5'd0);
            m_prio = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        @(posedge clock);
        cyc++;
        #1;
        chk("wr_regnum", bus.wr_regnum, m_reg);
        chk("wr_data", bus.wr_data, m_data);
        chk("writeenable", bus.writeenable, m_we);
        chk("busy", bus.busy, in_clear());
        if (t0) bus.req0_valid = 1'b0;
        if (t1) bus.req1_valid = 1'b0;
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge
    task automatic do_reset();
        bus.req0_valid  = 1'b0;
        bus.req1_valid  = 1'b0;
        bus.clear_start = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_we", bus.writeenable, 0);
        chk("rst_regnum", bus.wr_regnum, 0);
        chk("rst_data", bus.wr_data, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int exp_order [4] = '{0, 1, 0, 1};
        cyc = 0;
        model_reset();
        for (int i = 0; i < 32; i++) exp_rf[i] = '0;
        bus.req0_valid  = 1'b0;
        bus.req0_regnum = 5'd0;
        bus.req0_data   = '0;
        bus.req1_valid  = 1'b0;
        bus.req1_regnum = 5'd0;
        bus.req1_data   = '0;
        bus.clear_start = 1'b0;
        reset = 1'b1;
        #2;
        chk("init_busy", bus.busy, 0);
        chk("init_we", bus.writeenable, 0);
        chk("init_regnum", bus.wr_regnum, 0);
        chk("init_data", bus.wr_data, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        do_reset();
        step();
        step();

        // Single requester
        bus.req0_valid  = 1'b1;
        bus.req0_regnum = 5'd5;
        bus.req0_data   = 32'hDEADBEEF;
        step();
        chk("single_we", bus.writeenable, 1);
        chk("single_reg", bus.wr_regnum, 5);
        step();
        chk("single_we_off", bus.writeenable, 0);
        chk("rf5", rf[5], 32'hDEADBEEF);

        // Contention from reset: grants alternate starting with side 0
        do_reset();
        bus.req0_regnum = 5'd3;
        bus.req0_data   = 32'h11;
        bus.req1_regnum = 5'd4;
        bus.req1_data   = 32'h22;
        for (int i = 0; i < 4; i++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            step();
            chk("grant_order", 32'(bus.wr_regnum == 5'd4), exp_order[i]);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        chk("rf3", rf[3], 32'h11);
        chk("rf4", rf[4], 32'h22);

        // Write to register 0 is accepted but dropped
        bus.req1_valid  = 1'b1;
        bus.req1_regnum = 5'd0;
        bus.req1_data   = 32'hFFFF;
        step();
        chk("r0_accepted", 32'(t1), 1);
        chk("r0_we", bus.writeenable, 0);
        step();

        // Preload 1..31, then clear while req0 waits
        for (int k = 1; k < 32; k++) begin
            bus.req0_valid  = 1'b1;
            bus.req0_regnum = 5'(k);
            bus.req0_data   = 32'(k) * 32'h01010101 ^ 32'hA5;
            step();
        end
        step();
        chk("preload31", rf[31], 32'h1F1F1F1F ^ 32'hA5);
        bus.req0_valid  = 1'b1;
        bus.req0_regnum = 5'd7;
        bus.req0_data   = 32'hABCD;
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            step();
            chk("clr_req0_blocked", 32'(last_rdy0), 0);
        end
        for (int k = 1; k < 32; k++) chk("clr_zero", rf[k], 0);
        step();
        chk("clr_req0_accept_n32", 32'(last_rdy0), 1);
        chk("clr_req0_reg", bus.wr_regnum, 7);
        step();

        // Abort a clear with reset, then restart it
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        for (int k = 0; k < 10; k++) step();
        do_reset();
        step();
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        chk("restart_reg", bus.wr_regnum, 1);
        chk("restart_busy", bus.busy, 1);
        for (int k = 0; k < 32; k++) step();

        // Random traffic; valids held until accepted
        for (int n = 0; n < 400; n++) begin
            if (!bus.req0_valid && $urandom_range(2) == 0) begin
                bus.req0_valid  = 1'b1;
                bus.req0_regnum = 5'($urandom);
                bus.req0_data   = $urandom;
            end
            if (!bus.req1_valid && $urandom_range(2) == 0) begin
                bus.req1_valid  = 1'b1;
                bus.req1_regnum = 5'($urandom);
                bus.req1_data   = $urandom;
            end
            bus.clear_start = ($urandom_range(39) == 0);
            step();
        end
        bus.req0_valid  = 1'b0;
        bus.req1_valid  = 1'b0;
        bus.clear_start = 1'b0;
        for (int k = 0; k < 33; k++) step();
        for (int k = 1; k < 32; k++) chk("rand_rf", rf[k], exp_rf[k]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
